// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that shares one SPI engine between NREQ requesters.
// Each grant runs a full start/done four-phase exchange, ending in ack or err.
module spi_bus_arbiter #(
  parameter int NREQ        = 4,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*DATA_W-1:0]  wdata_i,
  input  logic [NREQ*SEL_W-1:0]   sel_i,
  output logic [NREQ-1:0]         ack_o,
  output logic [NREQ-1:0]         err_o,
  output logic [DATA_W-1:0]       rdata_o,
  output logic [NREQ-1:0]         grant_o,
  output logic                    busy_o,
  output logic [DATA_W-1:0]       spi_o,
  output logic [SEL_W-1:0]        spi_sel_o,
  output logic                    spi_start_o,
  input  logic [DATA_W-1:0]       spi_i,
  input  logic                    spi_done_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] rr;
  logic [IW-1:0] gidx;
  logic [IW-1:0] pick;
  logic          found;
  logic [15:0]   tcnt;
  logic          tmo;

  // first pending request at or above the rr pointer, wrapping
  always_comb begin
    int      idx;
    logic [IW-1:0] idx_l;
    idx   = 0;
    idx_l = '0;
    pick  = rr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_l = idx[IW-1:0];
      if (!found && req_i[idx_l]) begin
        found = 1'b1;
        pick  = idx_l;
      end
    end
  end

  assign tmo = (tcnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= S_IDLE;
      rr          <= '0;
      gidx        <= '0;
      tcnt        <= '0;
      ack_o       <= '0;
      err_o       <= '0;
      rdata_o     <= '0;
      grant_o     <= '0;
      busy_o      <= 1'b0;
      spi_o       <= '0;
      spi_sel_o   <= '0;
      spi_start_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            state       <= S_ISSUE;
            gidx        <= pick;
            grant_o     <= NREQ'(1) << pick;
            spi_o       <= wdata_i[pick*DATA_W +: DATA_W];
            spi_sel_o   <= sel_i[pick*SEL_W +: SEL_W];
            spi_start_o <= 1'b1;
            busy_o      <= 1'b1;
            tcnt        <= '0;
          end
        end
        S_ISSUE: begin
          tcnt <= tcnt + 16'd1;
          if (spi_done_i) begin
            rdata_o     <= spi_i;
            spi_start_o <= 1'b0;
            state       <= S_RELEASE;
          end else if (tmo) begin
            spi_start_o <= 1'b0;
            rdata_o     <= '0;
            err_o       <= grant_o;
            state       <= S_DONE;
          end
        end
        S_RELEASE: begin
          tcnt <= tcnt + 16'd1;
          if (!spi_done_i) begin
            ack_o <= grant_o;
            state <= S_DONE;
          end else if (tmo) begin
            rdata_o <= '0;
            err_o   <= grant_o;
            state   <= S_DONE;
          end
        end
        default: begin
          rr      <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          grant_o <= '0;
          ack_o   <= '0;
          err_o   <= '0;
          busy_o  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Randomized bench for spi_bus_arbiter with an engine responder
// and a round-robin reference model.
module tb_spi_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   req;
  logic [DW-1:0]  wdata_a [N];
  logic [SW-1:0]  sel_a [N];
  logic [N*DW-1:0] wbus;
  logic [N*SW-1:0] sbus;
  logic [N-1:0]   ack, err, grant;
  logic [DW-1:0]  rdata, spi_out, spi_rd;
  logic [SW-1:0]  spi_sel;
  logic           busy, spi_start, spi_done;

  for (genvar i = 0; i < N; i++) begin : g_bus
    assign wbus[i*DW +: DW] = wdata_a[i];
    assign sbus[i*SW +: SW] = sel_a[i];
  end

  spi_bus_arbiter #(
    .NREQ(N), .DATA_W(DW), .SEL_W(SW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req),
    .wdata_i(wbus), .sel_i(sbus),
    .ack_o(ack), .err_o(err), .rdata_o(rdata),
    .grant_o(grant), .busy_o(busy),
    .spi_o(spi_out), .spi_sel_o(spi_sel),
    .spi_start_o(spi_start), .spi_i(spi_rd),
    .spi_done_i(spi_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_rr  = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_model(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++)
      if (m[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // mode 0 normal, 1 done never rises, 2 done stuck high, 3 done early
  task automatic xfer(input int mode, input int dly, input int hold,
                      input logic [31:0] rd, output int g);
    int t0;
    int n;
    logic [DW-1:0] w_exp;
    logic [SW-1:0] s_exp;
    logic [DW-1:0] r_exp;
    g = pick_model(req, m_rr);
    if (g < 0) g = 0;
    w_exp = wdata_a[g];
    s_exp = sel_a[g];
    r_exp = (mode == 1 || mode == 2) ? '0 : rd;
    if (mode == 3) begin
      spi_rd   = rd;
      spi_done = 1'b1;
    end
    step();
    t0 = cyc;
    chk("start_rise", 32'(spi_start), 1);
    chk("grant", 32'(grant), 32'(1) << g);
    chk("spi_o", spi_out, w_exp);
    chk("spi_sel", 32'(spi_sel), 32'(s_exp));
    chk("busy", 32'(busy), 1);
    wdata_a[g] = $urandom;
    sel_a[g]   = SW'($urandom);
    if (mode == 3) begin
      step();
      chk("early_issue", 32'(spi_start), 0);
      repeat (hold) step();
      spi_done = 1'b0;
    end else if (mode != 1) begin
      repeat (dly) step();
      spi_rd   = rd;
      spi_done = 1'b1;
      step();
      chk("start_fall", 32'(spi_start), 0);
      spi_rd = $urandom;
      if (mode == 0) begin
        repeat (hold) step();
        spi_done = 1'b0;
      end
    end
    for (n = 0; n < 40; n++) begin
      if ((ack | err) != '0) break;
      if (mode == 2) chk("no_restart", 32'(spi_start), 0);
      step();
    end
    chk("resp_seen", 32'((ack | err) != '0), 1);
    chk("resp_grant", 32'(grant), 32'(1) << g);
    chk("resp_start", 32'(spi_start), 0);
    chk("spi_o_hold", spi_out, w_exp);
    chk("sel_hold", 32'(spi_sel), 32'(s_exp));
    chk("rdata", rdata, r_exp);
    if (mode == 1 || mode == 2) begin
      chk("err", 32'(err), 32'(1) << g);
      chk("ack_on_err", 32'(ack), 0);
      chk("tmo_cycles", cyc - t0, TO);
    end else begin
      chk("ack", 32'(ack), 32'(1) << g);
      chk("err_on_ack", 32'(err), 0);
    end
    req[g]   = 1'b0;
    spi_done = 1'b0;
    step();
    chk("idle_ack", 32'(ack), 0);
    chk("idle_err", 32'(err), 0);
    chk("idle_grant", 32'(grant), 0);
    chk("idle_busy", 32'(busy), 0);
    m_rr = (g + 1) % N;
  endtask

  initial begin
    int g;
    int mode;
    reset    = 1'b1;
    req      = '0;
    spi_done = 1'b0;
    spi_rd   = '0;
    for (int i = 0; i < N; i++) begin
      wdata_a[i] = $urandom;
      sel_a[i]   = SW'($urandom);
    end
    repeat (2) step();
    chk("rst_outs", 32'({ack, err, grant, busy, spi_start, spi_sel}), 0);
    chk("rst_spi_o", spi_out, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b0;
    m_rr  = 0;
    step();

    wdata_a[0] = 32'hA5A5_0001;
    sel_a[0]   = 2'd2;
    req        = 4'b0001;
    xfer(0, 3, 1, 32'h0000_BEEF, g);

    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      xfer(0, $urandom_range(0, 3), $urandom_range(0, 2), $urandom, g);
      chk("rr_order", g, (1 + i) % N);
      req = 4'b1111;
    end

    req = 4'b0100;
    xfer(1, 0, 0, 32'h0, g);
    req = 4'b0100;
    xfer(0, 1, 1, 32'h1234_5678, g);

    req = 4'b1000;
    xfer(2, 2, 0, 32'hDEAD_0000, g);

    req = 4'b0010;
    xfer(0, 0, 0, $urandom, g);
    req = 4'b1010;
    step();
    chk("pre_rst_grant", 32'(grant), 32'b1000);
    chk("pre_rst_start", 32'(spi_start), 1);
    reset = 1'b1;
    step();
    chk("mid_rst_outs", 32'({ack, err, grant, busy, spi_start}), 0);
    chk("mid_rst_rdata", rdata, 0);
    reset = 1'b0;
    m_rr  = 0;
    xfer(0, 1, 0, $urandom, g);
    chk("post_rst_grant", g, 1);

    req = 4'b0100;
    xfer(3, 0, 2, 32'hCAFE_F00D, g);

    for (int k = 0; k < 40; k++) begin
      if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
      mode = $urandom_range(0, 9);
      mode = (mode < 7) ? 0 : mode - 6;
      xfer(mode, $urandom_range(0, 4), $urandom_range(0, 3), $urandom, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
